// File: rtl/input_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | input_pkg                                                                |
// | Shared state encoding and timing defaults for the button input path.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package input_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    PRESS  = 3'd1,
    LONG   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } state_e;

  // Also consumed by the debounce stage, so keep them in one place.
  localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;
  localparam int unsigned DEF_GAP_CYCLES    = 25_000_000;
  localparam int unsigned DEF_CNT_W         = 27;

endpackage
`default_nettype wire

// File: rtl/btn_press_classifier_edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | edge_detect                                                              |
// | Registers a synchronous level and decodes its rising/falling edges.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic d_q;

  // Resetting to 1 hides a level already high at reset until it drops once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b1;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;

endmodule
`default_nettype wire

// File: rtl/btn_press_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btn_press_classifier                                                     |
// | Turns a debounced button level into short/long/repeat/double events.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module btn_press_classifier
  import input_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_db,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic double_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_rep_last  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

  logic rise;
  logic fall;

  edge_detect u_edge (
    .clk    (clk),
    .rst    (reset),
    .d_i    (btn_db),
    .rise_o (rise),
    .fall_o (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             double_q, double_d;
  logic             held_q, held_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    double_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) state_d = PRESS;
      end
      PRESS: begin
        // A release on the threshold edge is still a short press.
        if (fall) begin
          state_d = GAP;
        end else if (btn_db && (cnt_q == c_long_last)) begin
          state_d = LONG;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      LONG: begin
        if (fall) begin
          state_d = IDLE;
        end else if (cnt_q == c_rep_last) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      GAP: begin
        if (rise) begin
          state_d  = PRESS2;
          double_d = 1'b1;
        end else if (cnt_q == c_gap_last) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      PRESS2: begin
        if (fall) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    held_d = (state_d == PRESS) || (state_d == LONG) || (state_d == PRESS2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      double_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      double_q <= double_d;
      held_q   <= held_d;
    end
  end

  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = repeat_q;
  assign double_pulse = double_q;
  assign held         = held_q;

endmodule
`default_nettype wire
